// File: rtl/hamming_pkg.sv
// Shared SECDED definitions for the 16-bit packet used by hamming_enc and hamming_dec.
// Layout {P4,P3,P2,D10,P1,D9,D8,D7,P0,D6..D0}; P4 is the overall parity bit.
package hamming_pkg;

   localparam int PKT_W  = 16;
   localparam int DATA_W = 11;
   localparam int SYN_W  = 4;

   // CHK_MASK[i] marks the packet bits that feed syndrome bit i; packet[15] is in none.
   localparam logic [PKT_W-1:0] CHK_MASK [0:SYN_W-1] = '{
      16'h12DB, 16'h1C6D, 16'h370E, 16'h5770
   };

   // Indexed by syndrome: {valid, packet index}.
   localparam logic [4:0] SYN2POS [0:15] = '{
      5'h00, 5'h17, 5'h1B, 5'h10, 5'h1D, 5'h11, 5'h12, 5'h13,
      5'h1E, 5'h14, 5'h15, 5'h16, 5'h18, 5'h19, 5'h1A, 5'h1C
   };

   typedef enum logic [1:0] {
      CLEAN,
      SINGLE,
      DOUBLE
   } err_kind_e;

   function automatic logic [DATA_W-1:0] extract_data(input logic [PKT_W-1:0] pkt);
      return {pkt[12], pkt[10:8], pkt[6:0]};
   endfunction

endpackage

// File: rtl/hamming_syn_acc.sv
// Serial packet capture for hamming_dec: MSB-first shift register plus running
// syndrome and overall parity, with frame restart and a 16th-bit completion strobe.
module hamming_syn_acc
   import hamming_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_start,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             done,
   output logic [PKT_W-1:0] pkt_next,
   output logic [SYN_W-1:0] syn_next,
   output logic             ovr_next
);

   logic [3:0]       cnt;
   logic [3:0]       cnt_base;
   logic [3:0]       cnt_next;
   logic [3:0]       pos;
   logic [PKT_W-1:0] shift_q;
   logic [PKT_W-1:0] shift_base;
   logic [SYN_W-1:0] syn_q;
   logic [SYN_W-1:0] syn_base;
   logic             ovr_q;
   logic             ovr_base;

   // frame_start wipes the partial frame first, so a coincident bit becomes packet[15].
   always_comb begin
      cnt_base   = frame_start ? '0 : cnt;
      shift_base = frame_start ? '0 : shift_q;
      syn_base   = frame_start ? '0 : syn_q;
      ovr_base   = frame_start ? 1'b0 : ovr_q;
      cnt_next   = cnt_base;
      pkt_next   = shift_base;
      syn_next   = syn_base;
      ovr_next   = ovr_base;
      pos        = 4'd15 - cnt_base;
      done       = 1'b0;
      if (bit_valid) begin
         pkt_next = {shift_base[PKT_W-2:0], bit_in};
         for (int i = 0; i < SYN_W; i++) begin
            syn_next[i] = syn_base[i] ^ (bit_in & CHK_MASK[i][pos]);
         end
         ovr_next = ovr_base ^ bit_in;
         cnt_next = cnt_base + 4'd1;
         done     = (cnt_base == 4'd15);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         shift_q <= '0;
         syn_q   <= '0;
         ovr_q   <= 1'b0;
      end else if (done) begin
         cnt     <= '0;
         shift_q <= pkt_next;
         syn_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         cnt     <= cnt_next;
         shift_q <= pkt_next;
         syn_q   <= syn_next;
         ovr_q   <= ovr_next;
      end
   end

endmodule

// File: rtl/hamming_dec.sv
// Bit-serial SECDED decoder with a one-packet pending buffer and valid/ready output.
// Define HAMMING_DEC_STATS_EN to add saturating corrected/uncorrected word counters.
module hamming_dec
   import hamming_pkg::*;
#(
   parameter int DATA_W = 11,
   parameter int PKT_W  = 16,
   parameter int CNT_W  = 8
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_start,
   input  logic              bit_in,
   input  logic              bit_valid,
   output logic [DATA_W-1:0] data_out,
   output logic              err_single,
   output logic              err_double,
   output logic [3:0]        err_pos,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              overrun
`ifdef HAMMING_DEC_STATS_EN
   ,
   input  logic              stats_clr,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  uncorr_cnt
`endif
);

   if (DATA_W != hamming_pkg::DATA_W || PKT_W != hamming_pkg::PKT_W || CNT_W < 1) begin : g_width_check
      $error("hamming_dec: DATA_W must be 11, PKT_W must be 16, CNT_W must be positive");
   end

   logic             done;
   logic [PKT_W-1:0] pkt_next;
   logic [SYN_W-1:0] syn_next;
   logic             ovr_next;
   logic             pend;
   logic [PKT_W-1:0] pkt_hold;
   logic [SYN_W-1:0] syn_hold;
   logic             ovr_hold;
   logic             fire;
   err_kind_e        kind;
   logic [3:0]       pos_c;
   logic [PKT_W-1:0] pkt_corr;
   logic [4:0]       map;

   hamming_syn_acc u_syn_acc (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .done        (done),
      .pkt_next    (pkt_next),
      .syn_next    (syn_next),
      .ovr_next    (ovr_next)
   );

   assign fire = pend && (!out_valid || out_ready);
   assign map  = SYN2POS[syn_hold];

   // Zero syndrome with bad overall parity means only P4 flipped; the payload is untouched.
   always_comb begin
      kind     = CLEAN;
      pos_c    = '0;
      pkt_corr = pkt_hold;
      if (ovr_hold) begin
         if (syn_hold == '0) begin
            kind  = SINGLE;
            pos_c = 4'd15;
         end else if (map[4]) begin
            kind     = SINGLE;
            pos_c    = map[3:0];
            pkt_corr = pkt_hold ^ (16'd1 << map[3:0]);
         end else begin
            kind = DOUBLE;
         end
      end else if (syn_hold != '0) begin
         kind = DOUBLE;
      end
   end

   // A completion while a packet is still pending is dropped and reported via overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend       <= 1'b0;
         pkt_hold   <= '0;
         syn_hold   <= '0;
         ovr_hold   <= 1'b0;
         overrun    <= 1'b0;
         out_valid  <= 1'b0;
         data_out   <= '0;
         err_single <= 1'b0;
         err_double <= 1'b0;
         err_pos    <= '0;
      end else begin
         overrun <= done && pend;
         if (done && !pend) begin
            pend     <= 1'b1;
            pkt_hold <= pkt_next;
            syn_hold <= syn_next;
            ovr_hold <= ovr_next;
         end else if (fire) begin
            pend <= 1'b0;
         end
         if (fire) begin
            out_valid  <= 1'b1;
            data_out   <= extract_data(pkt_corr);
            err_single <= (kind == SINGLE);
            err_double <= (kind == DOUBLE);
            err_pos    <= pos_c;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef HAMMING_DEC_STATS_EN
   // Counters advance when a word is loaded into the output; clearing beats incrementing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (stats_clr) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else begin
         if (fire && kind == SINGLE && corr_cnt != '1) begin
            corr_cnt <= corr_cnt + CNT_W'(1);
         end
         if (fire && kind == DOUBLE && uncorr_cnt != '1) begin
            uncorr_cnt <= uncorr_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_hamming_dec.sv
// Scoreboard bench for hamming_dec: packets come from an independent golden encoder,
// expected words are queued at stimulus time and popped on each output handshake.
module tb_hamming_dec;

   typedef struct packed {
      logic [10:0] data;
      logic        single;
      logic        dbl;
      logic [3:0]  pos;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        frame_start;
   logic        bit_in;
   logic        bit_valid;
   logic [10:0] data_out;
   logic        err_single;
   logic        err_double;
   logic [3:0]  err_pos;
   logic        out_valid;
   logic        out_ready;
   logic        overrun;
`ifdef HAMMING_DEC_STATS_EN
   logic        stats_clr;
   logic [7:0]  corr_cnt;
   logic [7:0]  uncorr_cnt;
`endif

   exp_t scoreboard[$];
   exp_t monExp;
   int   checks = 0;
   int   errors = 0;
   int   overrunCycles = 0;

   hamming_dec dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .bit_in      (bit_in),
      .bit_valid   (bit_valid),
      .data_out    (data_out),
      .err_single  (err_single),
      .err_double  (err_double),
      .err_pos     (err_pos),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .overrun     (overrun)
`ifdef HAMMING_DEC_STATS_EN
      ,
      .stats_clr   (stats_clr),
      .corr_cnt    (corr_cnt),
      .uncorr_cnt  (uncorr_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic int dataPos(input int j);
      case (j)
         7:       return 8;
         8:       return 9;
         9:       return 10;
         10:      return 12;
         default: return j;
      endcase
   endfunction

   function automatic logic [3:0] dataCol(input int j);
      case (j)
         0:       return 4'd3;
         1:       return 4'd5;
         2:       return 4'd6;
         3:       return 4'd7;
         4:       return 4'd9;
         5:       return 4'd10;
         6:       return 4'd11;
         7:       return 4'd12;
         8:       return 4'd13;
         9:       return 4'd14;
         default: return 4'd15;
      endcase
   endfunction

   function automatic logic [15:0] encode(input logic [10:0] d);
      logic [15:0] p;
      logic [3:0]  par;
      logic [3:0]  col;
      p   = '0;
      par = '0;
      for (int j = 0; j < 11; j++) begin
         p[dataPos(j)] = d[j];
         col = dataCol(j);
         for (int i = 0; i < 4; i++) par[i] = par[i] ^ (d[j] & col[i]);
      end
      p[7]  = par[0];
      p[11] = par[1];
      p[13] = par[2];
      p[14] = par[3];
      p[15] = ^p[14:0];
      return p;
   endfunction

   function automatic logic [10:0] payload(input logic [15:0] p);
      return {p[12], p[10:8], p[6:0]};
   endfunction

   task automatic applyStimulus(input logic [15:0] pkt, input bit withStart);
      for (int b = 15; b >= 0; b--) begin
         bit_in      = pkt[b];
         bit_valid   = 1'b1;
         frame_start = withStart && (b == 15);
         tick();
      end
      bit_valid   = 1'b0;
      frame_start = 1'b0;
      bit_in      = 1'b0;
   endtask

   task automatic pushExpect(input logic [10:0] d, input logic s, input logic dbl, input logic [3:0] pos);
      exp_t e;
      e.data   = d;
      e.single = s;
      e.dbl    = dbl;
      e.pos    = pos;
      scoreboard.push_back(e);
   endtask

   task automatic sendClean(input logic [10:0] d);
      pushExpect(d, 1'b0, 1'b0, 4'd0);
      applyStimulus(encode(d), 1'b0);
   endtask

   task automatic sendSingle(input logic [10:0] d, input int k);
      pushExpect(d, 1'b1, 1'b0, 4'(k));
      applyStimulus(encode(d) ^ (16'h1 << k), 1'b0);
   endtask

   task automatic sendDouble(input logic [10:0] d, input int a, input int b);
      logic [15:0] p;
      p = encode(d) ^ (16'h1 << a) ^ (16'h1 << b);
      pushExpect(payload(p), 1'b0, 1'b1, 4'd0);
      applyStimulus(p, 1'b0);
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 200; i++) begin
         if (scoreboard.size() == 0) break;
         tick();
      end
      checkOutput("drain", 32'(scoreboard.size()), 32'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " out_valid"},  32'(out_valid),  32'd0);
      checkOutput({tag, " data_out"},   32'(data_out),   32'd0);
      checkOutput({tag, " err_single"}, 32'(err_single), 32'd0);
      checkOutput({tag, " err_double"}, 32'(err_double), 32'd0);
      checkOutput({tag, " err_pos"},    32'(err_pos),    32'd0);
      checkOutput({tag, " overrun"},    32'(overrun),    32'd0);
   endtask

   // Every handshake must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (scoreboard.size() == 0) begin
            checkOutput("unexpected word", 32'(data_out), 32'hFFFF_FFFF);
         end else begin
            monExp = scoreboard.pop_front();
            checkOutput("data_out",   32'(data_out),   32'(monExp.data));
            checkOutput("err_single", 32'(err_single), 32'(monExp.single));
            checkOutput("err_double", 32'(err_double), 32'(monExp.dbl));
            checkOutput("err_pos",    32'(err_pos),    32'(monExp.pos));
         end
      end
      if (rst_n && overrun) overrunCycles++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int lat;
      int a;
      int b;
      logic anyValid;
      logic [15:0] pa;
      logic [15:0] pb;
      logic [15:0] pc;

      rst_n       = 1'b0;
      frame_start = 1'b0;
      bit_in      = 1'b0;
      bit_valid   = 1'b0;
      out_ready   = 1'b0;
`ifdef HAMMING_DEC_STATS_EN
      stats_clr   = 1'b0;
`endif
      #12;
      checkAllZero("reset");
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      tick();

      $display("[TB] clean word and latency");
      out_ready = 1'b1;
      sendClean(11'h5A3);
      lat = 1;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) break;
         tick();
         lat++;
      end
      checkOutput("latency", 32'(lat), 32'd2);
      waitDrain();

      $display("[TB] single and parity-bit errors");
      sendSingle(11'h5A3, 9);
      sendSingle(11'h7FF, 15);
      sendSingle(11'h7FF, 7);
      waitDrain();

      $display("[TB] double error");
      sendDouble(11'h001, 0, 12);
      waitDrain();

      $display("[TB] sweep of single errors and random doubles");
      for (int k = 0; k < 16; k++) sendSingle(11'($urandom_range(0, 2047)), k);
      for (int n = 0; n < 6; n++) begin
         a = $urandom_range(0, 15);
         b = (a + $urandom_range(1, 15)) % 16;
         sendDouble(11'($urandom_range(0, 2047)), a, b);
      end
      for (int n = 0; n < 4; n++) sendClean(11'($urandom_range(0, 2047)));
      waitDrain();

      $display("[TB] backpressure and overrun");
      out_ready = 1'b0;
      pa = encode(11'h123) ^ 16'h0010;
      pb = encode(11'h456);
      pc = encode(11'h789);
      pushExpect(11'h123, 1'b1, 1'b0, 4'd4);
      pushExpect(11'h456, 1'b0, 1'b0, 4'd0);
      applyStimulus(pa, 1'b0);
      applyStimulus(pb, 1'b0);
      checkOutput("overrun before drop", 32'(overrunCycles), 32'd0);
      applyStimulus(pc, 1'b0);
      repeat (3) tick();
      checkOutput("overrun pulse", 32'(overrunCycles), 32'd1);
      checkOutput("held valid", 32'(out_valid), 32'd1);
      checkOutput("held data", 32'(data_out), 32'h123);
      out_ready = 1'b1;
      tick();
      checkOutput("zero bubble valid", 32'(out_valid), 32'd1);
      checkOutput("zero bubble data", 32'(data_out), 32'h456);
      waitDrain();

      $display("[TB] frame abort");
      for (int i = 0; i < 7; i++) begin
         bit_in    = 1'($urandom_range(0, 1));
         bit_valid = 1'b1;
         tick();
      end
      bit_valid = 1'b0;
      pushExpect(11'h2C7, 1'b0, 1'b0, 4'd0);
      applyStimulus(encode(11'h2C7), 1'b1);
      waitDrain();
      for (int i = 0; i < 7; i++) begin
         bit_in    = 1'($urandom_range(0, 1));
         bit_valid = 1'b1;
         tick();
      end
      bit_valid   = 1'b0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      sendSingle(11'h6B5, 2);
      waitDrain();

      $display("[TB] reset mid-frame with output valid");
      out_ready = 1'b0;
      applyStimulus(encode(11'h111) ^ 16'h0008, 1'b0);
      applyStimulus(encode(11'h222), 1'b0);
      for (int i = 0; i < 5; i++) begin
         bit_in    = 1'b1;
         bit_valid = 1'b1;
         tick();
      end
      checkOutput("pre-reset valid", 32'(out_valid), 32'd1);
      checkOutput("pre-reset single", 32'(err_single), 32'd1);
      rst_n = 1'b0;
      #1;
      checkAllZero("async reset");
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      @(posedge clk);
      #2;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      anyValid  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         anyValid = anyValid | out_valid;
         tick();
      end
      checkOutput("no word after reset", 32'(anyValid), 32'd0);
      sendClean(11'h3AB);
      waitDrain();
      checkOutput("overrun total", 32'(overrunCycles), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
